// File: rtl/rca_seq_add_ctrl_pkg.sv
// Shared definitions for the chunked add/subtract sequencer: chunk width and FSM state encoding.
package rca_seq_add_ctrl_pkg;

    localparam int CHUNK_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/rca_seq_add_ctrl_rca4.sv
// 4-bit ripple-carry adder shared by the sequencer; purely combinational.
module RCA_4_bit
    import rca_seq_add_ctrl_pkg::*;
(
    input  logic [CHUNK_W-1:0] i_a,
    input  logic [CHUNK_W-1:0] i_b,
    input  logic               i_c,
    output logic [CHUNK_W-1:0] o_s,
    output logic               o_c
);

    logic w_carry;

    // NOTE: every variable driven here gets a value before any branch or loop,
    // so no path can leave it unassigned and infer a latch.
    always_comb begin
        w_carry = i_c;
        o_s     = '0;
        for (int k = 0; k < CHUNK_W; k++) begin
            o_s[k]  = i_a[k] ^ i_b[k] ^ w_carry;
            w_carry = (i_a[k] & i_b[k]) | (w_carry & (i_a[k] ^ i_b[k]));
        end
        o_c = w_carry;
    end

endmodule

// File: rtl/rca_seq_add_ctrl.sv
// Multi-cycle WIDTH-bit add/subtract: feeds one 4-bit chunk per cycle, LSB first,
// through a single shared ripple-carry adder and presents the result on a held handshake.
module rca_seq_add_ctrl
    import rca_seq_add_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf,
    output logic             busy
);

    localparam int NCHUNK = WIDTH / CHUNK_W;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    if ((WIDTH % CHUNK_W) != 0 || WIDTH < CHUNK_W) begin : g_width_check
        $error("rca_seq_add_ctrl: WIDTH must be a multiple of 4 and at least 4");
    end

    state_t                   r_state;
    state_t                   w_state_next;
    logic [CW-1:0]            r_cnt;
    logic [WIDTH-1:0]         r_a;
    logic [WIDTH-1:0]         r_b;
    logic [WIDTH-1:0]         r_res;
    logic                     r_carry;
    logic [WIDTH-1:0]         r_sum;
    logic                     r_c_out;
    logic                     r_ovf;
    logic [CHUNK_W-1:0]       w_rca_s;
    logic                     w_rca_c;
    logic                     w_last;
    logic                     w_accept;
    logic [WIDTH+CHUNK_W-1:0] w_res_cat;

    RCA_4_bit u_rca (
        .i_a (r_a[CHUNK_W-1:0]),
        .i_b (r_b[CHUNK_W-1:0]),
        .i_c (r_carry),
        .o_s (w_rca_s),
        .o_c (w_rca_c)
    );

    assign w_last    = (r_cnt == CW'(NCHUNK - 1));
    assign w_accept  = in_valid && in_ready;
    // New chunk enters at the top; after NCHUNK shifts the whole result is aligned.
    assign w_res_cat = {w_rca_s, r_res};

    // NOTE: all clocked state uses non-blocking assignment so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (in_valid)  w_state_next = ST_RUN;
            ST_RUN:  if (w_last)    w_state_next = ST_DONE;
            ST_DONE: if (out_ready) w_state_next = ST_IDLE;
            default:                w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_sum   <= '0;
            r_c_out <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            // Subtraction is a + ~b + 1; the +1 rides in as the first chunk carry.
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= sub ? 1'b1 : c_in;
            r_cnt   <= '0;
        end else if (r_state == ST_RUN) begin
            r_a     <= r_a >> CHUNK_W;
            r_b     <= r_b >> CHUNK_W;
            r_res   <= w_res_cat[WIDTH+CHUNK_W-1:CHUNK_W];
            r_carry <= w_rca_c;
            r_cnt   <= r_cnt + CW'(1);
            if (w_last) begin
                r_sum   <= w_res_cat[WIDTH+CHUNK_W-1:CHUNK_W];
                r_c_out <= w_rca_c;
                // Overflow: carry out of the MSB differs from carry into it.
                r_ovf   <= w_rca_c ^ (w_rca_s[CHUNK_W-1] ^ r_a[CHUNK_W-1] ^ r_b[CHUNK_W-1]);
            end
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign busy      = (r_state != ST_IDLE);
    assign sum       = r_sum;
    assign c_out     = r_c_out;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_rca_seq_add_ctrl.sv
// Scoreboard bench for rca_seq_add_ctrl at WIDTH=16: directed cases, backpressure, mid-run reset, random ops.
module tb_rca_seq_add_ctrl;

    localparam int WIDTH = 16;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             c;
        logic             v;
    } res_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             ovf;
    logic             busy;

    res_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    rca_seq_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .ovf       (ovf),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference: full-width arithmetic, independent of chunking.
    function automatic res_t model(input logic [WIDTH-1:0] a_v, input logic [WIDTH-1:0] b_v,
                                   input logic ci, input logic sb);
        res_t           r;
        logic [WIDTH-1:0] bb;
        logic [WIDTH:0]   full;
        bb     = sb ? ~b_v : b_v;
        full   = {1'b0, a_v} + {1'b0, bb} + {{WIDTH{1'b0}}, (sb ? 1'b1 : ci)};
        r.sum  = full[WIDTH-1:0];
        r.c    = full[WIDTH];
        r.v    = (a_v[WIDTH-1] == bb[WIDTH-1]) && (full[WIDTH-1] != a_v[WIDTH-1]);
        return r;
    endfunction

    task automatic start_op(input logic [WIDTH-1:0] a_v, input logic [WIDTH-1:0] b_v,
                            input logic ci, input logic sb);
        check("in_ready_idle", in_ready, 1);
        a = a_v; b = b_v; c_in = ci; sub = sb; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        sb_q.push_back(model(a_v, b_v, ci, sb));
        check("in_ready_run", in_ready, 0);
    endtask

    task automatic wait_result();
        int lat = 0;
        while (!out_valid && lat < 16) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, 4);
    endtask

    task automatic pop_check(input string tag);
        res_t e;
        check({tag, "_sb_nonempty"}, (sb_q.size() > 0), 1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check({tag, "_sum"}, sum, e.sum);
            check({tag, "_cout"}, c_out, e.c);
            check({tag, "_ovf"}, ovf, e.v);
        end
    endtask

    task automatic handoff();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("handoff_out_valid", out_valid, 0);
        check("handoff_in_ready", in_ready, 1);
        check("handoff_busy", busy, 0);
    endtask

    task automatic run_op(input string tag, input logic [WIDTH-1:0] a_v, input logic [WIDTH-1:0] b_v,
                          input logic ci, input logic sb);
        start_op(a_v, b_v, ci, sb);
        wait_result();
        pop_check(tag);
        handoff();
    endtask

    initial begin
        res_t held;
        logic seen;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", c_out, 0);
        check("rst_ovf", ovf, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("add_1234", 16'h1234, 16'h4321, 1'b0, 1'b0);
        run_op("add_ffff", 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        run_op("add_7fff", 16'h7FFF, 16'h0001, 1'b0, 1'b0);
        run_op("add_cin",  16'h0005, 16'h0007, 1'b1, 1'b0);
        run_op("sub_5_7",  16'h0005, 16'h0007, 1'b0, 1'b1);
        run_op("sub_8000", 16'h8000, 16'h0001, 1'b0, 1'b1);
        check("sub_cin_ignored_model", model(16'h0005, 16'h0007, 1'b0, 1'b1),
              model(16'h0005, 16'h0007, 1'b1, 1'b1));

        // Backpressure: result must hold while new operands are offered and dropped.
        start_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0);
        wait_result();
        held = sb_q[0];
        for (int i = 0; i < 3; i++) begin
            a = 16'hAAAA; b = 16'h5555; sub = 1'b0; in_valid = 1'b1;
            @(posedge clk); #1;
            check("bp_out_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
            check("bp_sum_stable", sum, held.sum);
        end
        in_valid = 1'b0;
        pop_check("bp");
        handoff();
        check("bp_dropped", sb_q.size(), 0);
        run_op("after_bp", 16'h1111, 16'h2222, 1'b1, 1'b0);

        // Reset after two RUN edges abandons the operation.
        start_op(16'h3333, 16'h4444, 1'b0, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        check("mid_busy", busy, 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        sb_q.delete();
        check("mrst_out_valid", out_valid, 0);
        check("mrst_in_ready", in_ready, 1);
        check("mrst_sum", sum, 0);
        check("mrst_cout", c_out, 0);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            seen = seen | out_valid;
        end
        check("mrst_no_result", seen, 0);
        run_op("after_rst", 16'h8001, 16'h8001, 1'b0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            run_op("rand", WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
